// File: rtl/ram_init_arbiter_pkg.sv
// ram_init_pkg: shared types and helpers for ram_init_arbiter.
//   state_t   : clear-sweep FSM states (CLEAR, IDLE)
//   ARB_FIXED : fixed-priority arbitration, channel 0 highest
//   ARB_RR    : round-robin arbitration
//   clog2()   : ceiling log2, usable in constant expressions
package ram_init_pkg;

   typedef enum logic {
      CLEAR = 1'b0,
      IDLE  = 1'b1
   } state_t;

   localparam int unsigned ARB_FIXED = 0;
   localparam int unsigned ARB_RR    = 1;

   function automatic int unsigned clog2(input int unsigned v);
      int unsigned r;
      r = 0;
      for (int unsigned i = 0; i < 32; i++) begin
         if ((64'(1) << i) < 64'(v)) r = i + 1;
      end
      return r;
   endfunction

endpackage

// File: rtl/ram_init_arbiter_arb.sv
// rr_arbiter: one-hot grant selection across N_CH request lines.
//   clk_i  : clock
//   rst_i  : synchronous active-high reset (pointer back to channel 0)
//   req_i  : per-channel request levels
//   en_i   : grants may only be issued while high
//   adv_i  : advance the round-robin pointer past this cycle's winner
//   gnt_o  : one-hot grant (combinational)
module rr_arbiter
   import ram_init_pkg::*;
#(
   parameter int unsigned N_CH    = 2,
   parameter int unsigned RR_MODE = ARB_FIXED
) (
   input  logic            clk_i,
   input  logic            rst_i,
   input  logic [N_CH-1:0] req_i,
   input  logic            en_i,
   input  logic            adv_i,
   output logic [N_CH-1:0] gnt_o
);

   localparam int unsigned PW = (N_CH > 1) ? clog2(N_CH) : 1;

   logic [PW-1:0] ptr_q, ptr_d;
   int unsigned   rank;
   int unsigned   best;
   int unsigned   win;
   int unsigned   nxt;
   logic          found;

   // Each requester gets a rank equal to its distance from the pointer
   // (or its index in fixed mode); the lowest-ranked requester wins.
   always_comb begin
      rank  = 0;
      best  = N_CH;
      win   = 0;
      nxt   = 0;
      found = 1'b0;
      gnt_o = '0;
      ptr_d = ptr_q;
      for (int unsigned j = 0; j < N_CH; j++) begin
         if (RR_MODE == ARB_RR) rank = (j + N_CH - 32'(ptr_q)) % N_CH;
         else                   rank = j;
         if (en_i && req_i[j] && (rank < best)) begin
            best  = rank;
            win   = j;
            found = 1'b1;
         end
      end
      for (int unsigned j = 0; j < N_CH; j++) begin
         gnt_o[j] = found && (win == j);
      end
      if (adv_i && found) begin
         nxt   = (win + 1 >= N_CH) ? 0 : win + 1;
         ptr_d = PW'(nxt);
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) ptr_q <= '0;
      else       ptr_q <= ptr_d;
   end

endmodule

// File: rtl/ram_init_arbiter.sv
// ram_init_arbiter: single-port BRAM with a fill sweep after reset or on
// request, shared among N_CH request channels.
//   clk_sys     : system clock
//   reset       : synchronous active-high reset; restarts the sweep with FILL_DEFAULT
//   clear_i     : one-cycle pulse starting a sweep with fill_i
//   fill_i      : fill pattern, sampled with clear_i
//   busy_o      : high while the sweep runs (no grants)
//   ch_req_i    : per-channel request level
//   ch_we_i     : per-channel write enable
//   ch_addr_i   : packed addresses, channel k at [k*AW +: AW]
//   ch_din_i    : packed write data, channel k at [k*DW +: DW]
//   ch_gnt_o    : one-hot grant; access happens in the grant cycle
//   ch_rvalid_o : one-hot read-valid, one cycle after a read grant
//   dout_o      : shared read data, held between reads
module ram_init_arbiter
   import ram_init_pkg::*;
#(
   parameter int unsigned    DW           = 8,
   parameter int unsigned    DEPTH        = 409600,
   parameter int unsigned    AW           = 19,
   parameter int unsigned    N_CH         = 2,
   parameter int unsigned    RR_MODE      = ARB_FIXED,
   parameter logic [DW-1:0]  FILL_DEFAULT = 8'hFF
) (
   input  logic               clk_sys,
   input  logic               reset,
   input  logic               clear_i,
   input  logic [DW-1:0]      fill_i,
   output logic               busy_o,
   input  logic [N_CH-1:0]    ch_req_i,
   input  logic [N_CH-1:0]    ch_we_i,
   input  logic [N_CH*AW-1:0] ch_addr_i,
   input  logic [N_CH*DW-1:0] ch_din_i,
   output logic [N_CH-1:0]    ch_gnt_o,
   output logic [N_CH-1:0]    ch_rvalid_o,
   output logic [DW-1:0]      dout_o
);

   localparam int unsigned IW = (DEPTH > 1) ? clog2(DEPTH) : 1;

   state_t          state_q, state_d;
   logic [AW-1:0]   clr_addr_q, clr_addr_d;
   logic [DW-1:0]   fill_q, fill_d;
   logic [N_CH-1:0] rvalid_q;
   logic [DW-1:0]   dout_q;

   logic [N_CH-1:0] gnt;
   logic            idle;
   logic [AW-1:0]   sel_addr;
   logic [DW-1:0]   sel_din;
   logic            sel_we;
   logic            sel_in_range;
   logic            any_gnt;

   logic            mem_we;
   logic [AW-1:0]   mem_addr;
   logic [DW-1:0]   mem_wdata;
   logic [IW-1:0]   mem_idx;
   logic            rd_en;

   logic [DW-1:0]   mem [DEPTH];

   assign idle    = (state_q == IDLE);
   assign busy_o  = ~idle;
   assign any_gnt = |gnt;

   rr_arbiter #(
      .N_CH    (N_CH),
      .RR_MODE (RR_MODE)
   ) u_arb (
      .clk_i (clk_sys),
      .rst_i (reset),
      .req_i (ch_req_i),
      .en_i  (idle),
      .adv_i (any_gnt),
      .gnt_o (gnt)
   );

   // Select the granted channel's address/data; grant is one-hot.
   always_comb begin
      sel_addr = '0;
      sel_din  = '0;
      sel_we   = 1'b0;
      for (int unsigned j = 0; j < N_CH; j++) begin
         if (gnt[j]) begin
            sel_addr = ch_addr_i[j*AW +: AW];
            sel_din  = ch_din_i[j*DW +: DW];
            sel_we   = ch_we_i[j];
         end
      end
      sel_in_range = (32'(sel_addr) < DEPTH);
   end

   // Single RAM port: the sweep owns it in CLEAR, the winner in IDLE.
   always_comb begin
      if (idle) begin
         mem_we    = any_gnt && sel_we && sel_in_range;
         mem_addr  = sel_addr;
         mem_wdata = sel_din;
      end else begin
         mem_we    = 1'b1;
         mem_addr  = clr_addr_q;
         mem_wdata = fill_q;
      end
      mem_idx = IW'(mem_addr);
      rd_en   = idle && any_gnt && !sel_we;
   end

   always_comb begin
      state_d    = state_q;
      clr_addr_d = clr_addr_q;
      fill_d     = fill_q;
      unique case (state_q)
         CLEAR: begin
            if (clear_i) begin
               clr_addr_d = '0;
               fill_d     = fill_i;
            end else if (clr_addr_q == AW'(DEPTH - 1)) begin
               clr_addr_d = '0;
               state_d    = IDLE;
            end else begin
               clr_addr_d = clr_addr_q + AW'(1);
            end
         end
         IDLE: begin
            if (clear_i) begin
               clr_addr_d = '0;
               fill_d     = fill_i;
               state_d    = CLEAR;
            end
         end
         default: state_d = CLEAR;
      endcase
   end

   always_ff @(posedge clk_sys) begin
      if (reset) begin
         state_q    <= CLEAR;
         clr_addr_q <= '0;
         fill_q     <= FILL_DEFAULT;
      end else begin
         state_q    <= state_d;
         clr_addr_q <= clr_addr_d;
         fill_q     <= fill_d;
      end
   end

   always_ff @(posedge clk_sys) begin
      if (mem_we) mem[mem_idx] <= mem_wdata;
   end

   // Out-of-range reads still complete, returning zero.
   always_ff @(posedge clk_sys) begin
      if (reset) begin
         rvalid_q <= '0;
         dout_q   <= '0;
      end else begin
         rvalid_q <= rd_en ? (gnt & ~ch_we_i) : '0;
         if (rd_en) dout_q <= sel_in_range ? mem[mem_idx] : '0;
      end
   end

   assign ch_gnt_o    = gnt;
   assign ch_rvalid_o = rvalid_q;
   assign dout_o      = dout_q;

endmodule

// File: tb/tb_ram_init_arbiter.sv
module tb_ram_init_arbiter;

   logic        clk = 1'b0;
   logic        reset;
   logic        clear;
   logic [7:0]  fill;

   logic [1:0]  req2, we2, gnt2, rv2;
   logic [9:0]  addr2;
   logic [15:0] din2;
   logic        busy;
   logic [7:0]  dout;

   logic [2:0]  req3, we3, gnt_r, rv_r, gnt_f, rv_f;
   logic [14:0] addr3;
   logic [23:0] din3;
   logic        busy_r, busy_f;
   logic [7:0]  dout_r, dout_f;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   ram_init_arbiter #(.DW(8), .DEPTH(16), .AW(5), .N_CH(2), .RR_MODE(0), .FILL_DEFAULT(8'hFF)) dut (
      .clk_sys(clk), .reset(reset), .clear_i(clear), .fill_i(fill), .busy_o(busy),
      .ch_req_i(req2), .ch_we_i(we2), .ch_addr_i(addr2), .ch_din_i(din2),
      .ch_gnt_o(gnt2), .ch_rvalid_o(rv2), .dout_o(dout));

   ram_init_arbiter #(.DW(8), .DEPTH(16), .AW(5), .N_CH(3), .RR_MODE(1), .FILL_DEFAULT(8'hFF)) dut_rr (
      .clk_sys(clk), .reset(reset), .clear_i(1'b0), .fill_i(8'h00), .busy_o(busy_r),
      .ch_req_i(req3), .ch_we_i(we3), .ch_addr_i(addr3), .ch_din_i(din3),
      .ch_gnt_o(gnt_r), .ch_rvalid_o(rv_r), .dout_o(dout_r));

   ram_init_arbiter #(.DW(8), .DEPTH(16), .AW(5), .N_CH(3), .RR_MODE(0), .FILL_DEFAULT(8'hFF)) dut_fp (
      .clk_sys(clk), .reset(reset), .clear_i(1'b0), .fill_i(8'h00), .busy_o(busy_f),
      .ch_req_i(req3), .ch_we_i(we3), .ch_addr_i(addr3), .ch_din_i(din3),
      .ch_gnt_o(gnt_f), .ch_rvalid_o(rv_f), .dout_o(dout_f));

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   // Counts cycles with busy high (bounded); notes any grant seen meanwhile.
   task automatic count_busy(output int n, output logic saw_gnt);
      n = 0;
      saw_gnt = 1'b0;
      for (int c = 0; c < 40; c++) begin
         if (!busy) break;
         n++;
         if (gnt2 !== 2'b00) saw_gnt = 1'b1;
         tick();
      end
   endtask

   task automatic do_write(input int ch, input logic [4:0] a, input logic [7:0] d, input string nm);
      logic [1:0] oh;
      oh = '0;
      oh[ch] = 1'b1;
      req2 = oh; we2 = 2'b11; addr2 = {a, a}; din2 = {d, d};
      #1;
      total++;
      if (gnt2 !== oh) begin
         bad++;
         $display("FAIL %s wr gnt a=%0d: got %b want %b", nm, a, gnt2, oh);
      end
      tick();
      req2 = '0;
      total++;
      if (rv2 !== 2'b00) begin
         bad++;
         $display("FAIL %s wr rvalid a=%0d: got %b want 00", nm, a, rv2);
      end
   endtask

   task automatic do_read(input int ch, input logic [4:0] a, input logic [7:0] exp, input string nm);
      logic [1:0] oh;
      oh = '0;
      oh[ch] = 1'b1;
      req2 = oh; we2 = 2'b00; addr2 = {a, a};
      #1;
      total++;
      if (gnt2 !== oh) begin
         bad++;
         $display("FAIL %s rd gnt a=%0d: got %b want %b", nm, a, gnt2, oh);
      end
      tick();
      req2 = '0;
      total++;
      if (rv2 !== oh || dout !== exp) begin
         bad++;
         $display("FAIL %s rd a=%0d: rvalid=%b dout=%h want rvalid=%b dout=%h", nm, a, rv2, dout, oh, exp);
      end
   endtask

   task automatic test_reset;
      int   n;
      logic g;
      total++;
      if (busy !== 1'b1 || gnt2 !== 2'b00 || rv2 !== 2'b00 || dout !== 8'h00) begin
         bad++;
         $display("FAIL reset_vals: busy=%b gnt=%b rv=%b dout=%h want 1 00 00 00", busy, gnt2, rv2, dout);
      end
      reset = 1'b0;
      req2 = 2'b01; we2 = 2'b00; addr2 = '0;
      count_busy(n, g);
      req2 = '0;
      total++;
      if (n != 16) begin
         bad++;
         $display("FAIL reset_sweep_len: got %0d want 16", n);
      end
      total++;
      if (g !== 1'b0) begin
         bad++;
         $display("FAIL reset_sweep_nogrant: got grant during sweep want none");
      end
      for (int a = 0; a < 16; a++) do_read(a % 2, 5'(a), 8'hFF, "clr_ff");
   endtask

   task automatic test_basic;
      do_write(0, 5'd5, 8'hA5, "basic");
      do_read(0, 5'd5, 8'hA5, "basic");
      tick();
      total++;
      if (rv2 !== 2'b00 || dout !== 8'hA5) begin
         bad++;
         $display("FAIL dout_hold: rvalid=%b dout=%h want 00 a5", rv2, dout);
      end
      do_write(1, 5'd9, 8'h5A, "basic_ch1");
      do_read(1, 5'd9, 8'h5A, "basic_ch1");
      do_read(0, 5'd5, 8'hA5, "basic_keep");
   endtask

   task automatic test_arbitration;
      logic [2:0] seq [6];
      seq = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100};
      req3 = 3'b111; we3 = 3'b111; addr3 = '0; din3 = '0;
      for (int k = 0; k < 6; k++) begin
         #1;
         total++;
         if (gnt_r !== seq[k] || gnt_f !== 3'b001) begin
            bad++;
            $display("FAIL arb_all cyc%0d: rr=%b fp=%b want rr=%b fp=001", k, gnt_r, gnt_f, seq[k]);
         end
         tick();
      end
      req3 = '0;
      tick();
      req3 = 3'b110;
      #1;
      total++;
      if (gnt_r !== 3'b010 || gnt_f !== 3'b010) begin
         bad++;
         $display("FAIL arb_110: rr=%b fp=%b want 010 010", gnt_r, gnt_f);
      end
      tick();
      req3 = 3'b101;
      #1;
      total++;
      if (gnt_r !== 3'b100 || gnt_f !== 3'b001) begin
         bad++;
         $display("FAIL arb_101: rr=%b fp=%b want 100 001", gnt_r, gnt_f);
      end
      tick();
      req3 = '0;
   endtask

   task automatic test_midsweep;
      int   n;
      logic g;
      reset = 1'b1;
      tick();
      reset = 1'b0;
      repeat (7) tick();
      clear = 1'b1; fill = 8'h00;
      #1;
      total++;
      if (busy !== 1'b1) begin
         bad++;
         $display("FAIL mid_busy: got %b want 1", busy);
      end
      tick();
      clear = 1'b0;
      count_busy(n, g);
      total++;
      if (n != 16) begin
         bad++;
         $display("FAIL mid_sweep_len: got %0d want 16", n);
      end
      for (int a = 0; a < 16; a++) do_read(0, 5'(a), 8'h00, "mid_fill");
   endtask

   task automatic test_same_cycle;
      int   n;
      logic g;
      req2 = 2'b10; we2 = 2'b11; addr2 = {5'd3, 5'd3}; din2 = {8'h3C, 8'h3C};
      clear = 1'b1; fill = 8'h11;
      #1;
      total++;
      if (gnt2 !== 2'b10 || busy !== 1'b0) begin
         bad++;
         $display("FAIL same_gnt: gnt=%b busy=%b want 10 0", gnt2, busy);
      end
      tick();
      clear = 1'b0; req2 = '0;
      count_busy(n, g);
      total++;
      if (n != 16) begin
         bad++;
         $display("FAIL same_sweep_len: got %0d want 16", n);
      end
      do_read(1, 5'd3, 8'h11, "same_a3");
      do_read(0, 5'd15, 8'h11, "same_a15");
   endtask

   task automatic test_oor;
      do_write(0, 5'd4, 8'h44, "oor_pre");
      do_write(0, 5'd20, 8'h77, "oor_wr");
      do_read(0, 5'd20, 8'h00, "oor_rd");
      do_read(1, 5'd4, 8'h44, "oor_a4");
      do_read(0, 5'd5, 8'h11, "oor_a5");
   endtask

   initial begin
      reset = 1'b1; clear = 1'b0; fill = '0;
      req2 = '0; we2 = '0; addr2 = '0; din2 = '0;
      req3 = '0; we3 = '0; addr3 = '0; din3 = '0;
      repeat (3) tick();
      test_reset();
      test_basic();
      test_arbitration();
      test_midsweep();
      test_same_cycle();
      test_oor();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
